dropout_mask_gen: RTL and testbench
===================================

# dropout_mask_gen

- **Function:** LFSR-based random keep-mask generator that produces one 8-bit dropout mask per neuron group.
- **Mask rule:** each bit is 1 (keep) or 0 (drop), decided by comparing a pseudo-random byte against a programmable rate threshold.
- **Placement:** directly upstream of the dropout stage. It replaces simulation-only `$random` calls with a synthesizable, seedable, reproducible source.
- **Handshake:** masks leave through a valid/ready interface, so the consumer can apply them at its own pace.

## Interface
Parameters:
- `SEED`, 16'hACE1: LFSR value after reset. Also substituted whenever a zero seed is loaded.
- `TAPS`, 16'hB400: Galois LFSR feedback mask (x^16+x^14+x^13+x^11+1).

Ports (one clock; reset is synchronous and active-high):
- `clk`, in, 1: clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `ui_ena`, in, 1: generation enable. Low freezes the LFSR and the lane counter.
- `rate`, in, 8: drop threshold. A lane is dropped when its random byte < `rate`.
- `seed_load`, in, 1: one-cycle pulse that loads `seed_in` into the LFSR.
- `seed_in`, in, 16: seed value.
- `mask_ready`, in, 1: consumer accepts the mask.
- `mask_valid`, out, 1: the `mask` output holds an unconsumed mask.
- `mask`, out, 8: keep mask; bit i=1 means lane i passes.
- `busy`, out, 1: high while a mask is being assembled or stalled (state GEN or HOLD).
- `keep_count`, out, 4: popcount of `mask`. Present only with `DROPOUT_MASK_COUNT_EN`.

## Operation
- **LFSR step:** `lfsr` is 16-bit Galois, shifting right. `lsb = lfsr[0]`; `lfsr = lfsr >> 1`; if `lsb`, `lfsr ^= TAPS`.
- **Lane bit:** in each generating cycle, the random byte is `lfsr[7:0]` *before* the step.
  - `asm[lane] <= (byte >= rate_q)`.
  - The LFSR then steps and `lane` increments.
- **Rate latch:** `rate_q` is latched from `rate` in the lane-0 cycle, and lane 0 itself compares against the live `rate`. Lanes 1–7 use `rate_q`, so `rate` changes mid-mask take effect from the next mask.
- **FSM states:**
  - IDLE: `ui_ena`=0, no partial mask.
  - GEN: assembling lanes 0–7.
  - HOLD: mask complete, output register occupied.
- **FSM transitions:**
  - IDLE -> GEN when `ui_ena`=1.
  - GEN with `ui_ena`=0 freezes in place: LFSR, `lane` and `asm` are held. `busy` stays 1 if `lane`≠0.
  - GEN at lane 7: if the output is free (`!mask_valid`, or `mask_valid && mask_ready` this cycle), load `mask` and set `mask_valid`=1, reset `lane` to 0, and stay in GEN. Otherwise go to HOLD without stepping the LFSR for lane 7.
  - HOLD -> GEN on the first cycle the output frees. Lane 7 is sampled that cycle and the mask is loaded at the same edge.
- **Output register:**
  - `mask_valid` clears on `mask_valid && mask_ready` unless a new mask loads at the same edge.
  - `mask` is stable while `mask_valid`=1 and `mask_ready`=0.
- **Seed load:** `seed_load`=1 sets `lfsr <= (seed_in==0) ? SEED : seed_in`, clears `lane` and `asm`, and discards any partial mask (next state GEN if `ui_ena`, else IDLE).
  - The output register and `mask_valid` are unaffected.
  - No step or sample occurs that cycle.
- **Priority:** `reset` > `seed_load` > generation step.
- **Lock-up:** the LFSR can never hold 0.

## Timing
- **Reset values:**
  - `lfsr`=`SEED`, `lane`=0, `asm`=0, `rate_q`=0, state IDLE.
  - `mask_valid`=0, `mask`=8'h00, `busy`=0, `keep_count`=0.
- **First mask:** with `ui_ena` held from cycle 0, lanes are sampled in cycles 0–7 and `mask_valid` rises at the edge ending cycle 7, i.e. visible in cycle 8. This is the 8-cycle latency.
- **Throughput:** one mask per 8 enabled cycles when `mask_ready`=1 continuously; no bubbles.
- **Backpressure:** if `mask_ready`=0, the generator completes lanes 0–6 of the next mask and then stalls in HOLD. After `mask_ready` rises, the next mask appears one edge later.
- **Reset mid-operation:** all state returns to reset values at that edge; the partial mask and the pending output are lost.

## Configuration
- `DROPOUT_MASK_COUNT_EN` defined: port `keep_count[3:0]` exists. It is registered alongside `mask`, equals popcount of the loaded mask (range 0–8), and resets to 0.
- `DROPOUT_MASK_COUNT_EN` undefined: the port and its logic are absent; all other behaviour is identical.

## Test plan
- **Reset and first mask:** reset, then `ui_ena`=1, `rate`=0, `mask_ready`=1 -> `mask_valid` first high in cycle 8, `mask`=8'hFF, `keep_count`=8. Thereafter a new 8'hFF every 8 cycles.
- **Golden model:** `rate`=8'h80, default `SEED`, run 64 masks against a software Galois-LFSR model -> every `mask` bit-exact. Drop fraction over 512 lanes is between 40% and 60%.
- **Backpressure:** `mask_ready`=0 for 30 cycles after the first valid -> `mask` stable, `busy`=1, state HOLD. Raise `mask_ready` -> the current mask is consumed and the next mask is valid on the following cycle, matching the model.
- **Seed load:** `seed_load`=1 with `seed_in`=16'h0000 mid-mask (`lane`=3) -> `lfsr`=16'hACE1, partial mask discarded, pending output retained. The next mask equals the first post-reset mask.
- **Enable gating and rate latch:** toggle `ui_ena` low for 5 cycles at `lane`=4, and change `rate` from 8'h00 to 8'hFF at `lane`=2 -> lanes resume without skipping. The current mask uses `rate_q`=0 (8'hFF), and the following mask uses 8'hFF.
- **Reset mid-operation:** assert `reset` while `mask_valid`=1 in HOLD -> next cycle all outputs at reset values and `lfsr`=16'hACE1.

Source files
------------

// File: rtl/dropout_mask_gen.sv
// LFSR-based dropout keep-mask generator: one 8-bit mask per 8 enabled cycles, valid/ready output.
// Optional keep_count popcount output is built when DROPOUT_MASK_COUNT_EN is defined.
module dropout_mask_gen #(
    parameter logic [15:0] SEED = 16'hACE1,
    parameter logic [15:0] TAPS = 16'hB400
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ui_ena,
    input  logic [7:0]  rate,
    input  logic        seed_load,
    input  logic [15:0] seed_in,
    input  logic        mask_ready,
    output logic        mask_valid,
    output logic [7:0]  mask,
`ifdef DROPOUT_MASK_COUNT_EN
    output logic [3:0]  keep_count,
`endif
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, GEN, HOLD} state_t;

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [2:0]  lane_q, lane_d;
    logic [6:0]  asm_q, asm_d;
    logic [7:0]  rate_q, rate_d;
    logic [7:0]  mask_q, mask_d;
    logic        mask_valid_q, mask_valid_d;

    logic        out_free;
    logic        load;
    logic [7:0]  thr;
    logic        lane_bit;
    logic [15:0] lfsr_nxt;

    always_comb begin
        state_d      = state_q;
        lfsr_d       = lfsr_q;
        lane_d       = lane_q;
        asm_d        = asm_q;
        rate_d       = rate_q;
        mask_d       = mask_q;
        mask_valid_d = mask_valid_q;
        load         = 1'b0;

        out_free = !mask_valid_q || mask_ready;
        // Lane 0 compares against the live rate, which is latched for lanes 1-7.
        thr      = (lane_q == 3'd0) ? rate : rate_q;
        lane_bit = (lfsr_q[7:0] >= thr);
        lfsr_nxt = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : 16'h0000);

        if (mask_valid_q && mask_ready)
            mask_valid_d = 1'b0;

        if (seed_load) begin
            lfsr_d  = (seed_in == 16'h0000) ? SEED : seed_in;
            lane_d  = 3'd0;
            asm_d   = 7'd0;
            state_d = ui_ena ? GEN : IDLE;
        end else if (ui_ena) begin
            case (state_q)
                IDLE, GEN: begin
                    state_d = GEN;
                    if (lane_q == 3'd0)
                        rate_d = rate;
                    if (lane_q == 3'd7) begin
                        if (out_free) load = 1'b1;
                        else          state_d = HOLD;
                    end else begin
                        asm_d[lane_q] = lane_bit;
                        lfsr_d        = lfsr_nxt;
                        lane_d        = lane_q + 3'd1;
                    end
                end
                HOLD: begin
                    if (out_free) begin
                        load    = 1'b1;
                        state_d = GEN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q == GEN && lane_q == 3'd0) begin
            // Nothing partial is held, so a disabled generator is simply idle.
            state_d = IDLE;
        end

        if (load) begin
            mask_d       = {lane_bit, asm_q};
            mask_valid_d = 1'b1;
            lfsr_d       = lfsr_nxt;
            lane_d       = 3'd0;
            asm_d        = 7'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            lfsr_q       <= SEED;
            lane_q       <= 3'd0;
            asm_q        <= 7'd0;
            rate_q       <= 8'd0;
            mask_q       <= 8'd0;
            mask_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            lane_q       <= lane_d;
            asm_q        <= asm_d;
            rate_q       <= rate_d;
            mask_q       <= mask_d;
            mask_valid_q <= mask_valid_d;
        end
    end

`ifdef DROPOUT_MASK_COUNT_EN
    logic [3:0] keep_count_q, keep_count_d;

    always_comb begin
        keep_count_d = keep_count_q;
        if (load)
            keep_count_d = 4'($countones(mask_d));
    end

    always_ff @(posedge clk) begin
        if (reset) keep_count_q <= 4'd0;
        else       keep_count_q <= keep_count_d;
    end

    assign keep_count = keep_count_q;
`endif

    assign mask       = mask_q;
    assign mask_valid = mask_valid_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_dropout_mask_gen.sv
// Directed bench for dropout_mask_gen: first-mask table per rate, golden LFSR run, and corner sequences.
module tb_dropout_mask_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ui_ena = 1'b0;
    logic [7:0]  rate = 8'd0;
    logic        seed_load = 1'b0;
    logic [15:0] seed_in = 16'd0;
    logic        mask_ready = 1'b0;
    logic        mask_valid;
    logic [7:0]  mask;
    logic        busy;
`ifdef DROPOUT_MASK_COUNT_EN
    logic [3:0]  keep_count;
`endif

    int checks = 0;
    int failures = 0;

    dropout_mask_gen dut (
        .clk(clk),
        .reset(reset),
        .ui_ena(ui_ena),
        .rate(rate),
        .seed_load(seed_load),
        .seed_in(seed_in),
        .mask_ready(mask_ready),
        .mask_valid(mask_valid),
        .mask(mask),
`ifdef DROPOUT_MASK_COUNT_EN
        .keep_count(keep_count),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] rate;
        logic [7:0] exp_mask;
    } vec_t;

    vec_t tv[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1; ui_ena = 1'b0; seed_load = 1'b0; mask_ready = 1'b0; rate = 8'd0;
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!mask_valid && n < 40) begin
            tick();
            n++;
        end
    endtask

    function automatic logic [15:0] step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [15:0] adv8(input logic [15:0] s);
        logic [15:0] t = s;
        for (int i = 0; i < 8; i++) t = step(t);
        return t;
    endfunction

    function automatic logic [7:0] mmask(input logic [15:0] s, input logic [7:0] r);
        logic [15:0] t = s;
        logic [7:0]  m = 8'd0;
        for (int i = 0; i < 8; i++) begin
            m[i] = (t[7:0] >= r);
            t = step(t);
        end
        return m;
    endfunction

    initial begin
        int n;
        int drops;
        int bad;
        logic [15:0] s;
        logic [7:0]  e0, e1;

        // First mask after reset; LFSR bytes from ACE1 are E1 70 38 9C 4E 27 13 89.
        tv[0] = '{8'h00, 8'hFF};
        tv[1] = '{8'h80, 8'h89};
        tv[2] = '{8'hFF, 8'h00};
        tv[3] = '{8'h40, 8'h9B};
        tv[4] = '{8'h50, 8'h8B};
        tv[5] = '{8'h14, 8'hBF};
        tv[6] = '{8'h13, 8'hFF};
        tv[7] = '{8'hE1, 8'h01};
        tv[8] = '{8'hE2, 8'h00};

        // Reset state, then a stream of all-keep masks.
        do_reset();
        chk("rst_valid", 32'(mask_valid), 32'd0);
        chk("rst_mask", 32'(mask), 32'h00);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_lfsr", 32'(dut.lfsr_q), 32'hACE1);
`ifdef DROPOUT_MASK_COUNT_EN
        chk("rst_kc", 32'(keep_count), 32'd0);
`endif
        rate = 8'h00; ui_ena = 1'b1; mask_ready = 1'b1;
        wait_valid(n);
        chk("r0_latency", 32'(n), 32'd8);
`ifdef DROPOUT_MASK_COUNT_EN
        chk("r0_kc", 32'(keep_count), 32'd8);
`endif
        repeat (8) tick();
        chk("r0_second_valid", 32'(mask_valid), 32'd1);
        chk("r0_second_mask", 32'(mask), 32'hFF);

        for (int i = 0; i < 9; i++) begin
            do_reset();
            rate = tv[i].rate; ui_ena = 1'b1; mask_ready = 1'b1;
            wait_valid(n);
            chk($sformatf("tv%0d_latency", i), 32'(n), 32'd8);
            chk($sformatf("tv%0d_mask", i), 32'(mask), 32'(tv[i].exp_mask));
`ifdef DROPOUT_MASK_COUNT_EN
            chk($sformatf("tv%0d_kc", i), 32'(keep_count), 32'($countones(tv[i].exp_mask)));
`endif
        end

        // Golden run: 64 back-to-back masks at rate 0x80.
        do_reset();
        rate = 8'h80; ui_ena = 1'b1; mask_ready = 1'b1;
        wait_valid(n);
        chk("gold_latency", 32'(n), 32'd8);
        s = 16'hACE1;
        drops = 0;
        for (int k = 0; k < 64; k++) begin
            chk($sformatf("gold_mask%0d", k), 32'(mask), 32'(mmask(s, 8'h80)));
            drops += 8 - $countones(mask);
            s = adv8(s);
            if (k < 63) repeat (8) tick();
        end
        chk("gold_drop_frac", 32'((drops * 10 >= 2048) && (drops * 10 <= 3072)), 32'd1);

        // Backpressure: stall in HOLD, then release.
        do_reset();
        rate = 8'h80; ui_ena = 1'b1; mask_ready = 1'b0;
        e0 = mmask(16'hACE1, 8'h80);
        s  = adv8(16'hACE1);
        e1 = mmask(s, 8'h80);
        wait_valid(n);
        chk("bp_latency", 32'(n), 32'd8);
        chk("bp_mask0", 32'(mask), 32'(e0));
        bad = 0;
        repeat (30) begin
            tick();
            if (mask !== e0 || mask_valid !== 1'b1 || busy !== 1'b1) bad++;
        end
        chk("bp_stable", 32'(bad), 32'd0);
        chk("bp_lane", 32'(dut.lane_q), 32'd7);
        chk("bp_lfsr_frozen", 32'(dut.lfsr_q), 32'(adv8(s) == 16'h0 ? 16'h0 : step(step(step(step(step(step(step(s)))))))));
        mask_ready = 1'b1;
        tick();
        chk("bp_next_valid", 32'(mask_valid), 32'd1);
        chk("bp_next_mask", 32'(mask), 32'(e1));
        chk("bp_next_lfsr", 32'(dut.lfsr_q), 32'(adv8(s)));

        // Reset while a mask is pending in HOLD.
        mask_ready = 1'b0;
        repeat (20) tick();
        chk("rm_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rm_valid", 32'(mask_valid), 32'd0);
        chk("rm_mask", 32'(mask), 32'h00);
        chk("rm_busy", 32'(busy), 32'd0);
        chk("rm_lfsr", 32'(dut.lfsr_q), 32'hACE1);
`ifdef DROPOUT_MASK_COUNT_EN
        chk("rm_kc", 32'(keep_count), 32'd0);
`endif

        // Zero seed load mid-mask keeps the pending output and restarts the sequence.
        do_reset();
        rate = 8'h80; ui_ena = 1'b1; mask_ready = 1'b0;
        wait_valid(n);
        repeat (3) tick();
        chk("sl_lane_before", 32'(dut.lane_q), 32'd3);
        seed_load = 1'b1; seed_in = 16'h0000;
        tick();
        seed_load = 1'b0;
        chk("sl_lfsr", 32'(dut.lfsr_q), 32'hACE1);
        chk("sl_lane", 32'(dut.lane_q), 32'd0);
        chk("sl_valid_kept", 32'(mask_valid), 32'd1);
        chk("sl_mask_kept", 32'(mask), 32'h89);
        mask_ready = 1'b1;
        tick();
        chk("sl_consumed", 32'(mask_valid), 32'd0);
        wait_valid(n);
        chk("sl_latency", 32'(n), 32'd7);
        chk("sl_mask", 32'(mask), 32'h89);

        // Enable gating at lane 4 and a rate change at lane 2.
        do_reset();
        rate = 8'h00; ui_ena = 1'b1; mask_ready = 1'b1;
        tick(); tick();
        chk("en_lane2", 32'(dut.lane_q), 32'd2);
        rate = 8'hFF;
        tick(); tick();
        ui_ena = 1'b0;
        repeat (5) tick();
        chk("en_frozen_lane", 32'(dut.lane_q), 32'd4);
        chk("en_frozen_busy", 32'(busy), 32'd1);
        chk("en_frozen_lfsr", 32'(dut.lfsr_q), 32'(step(step(step(step(16'hACE1))))));
        ui_ena = 1'b1;
        wait_valid(n);
        chk("en_latency", 32'(n), 32'd4);
        chk("en_mask_rate_q", 32'(mask), 32'hFF);
        repeat (8) tick();
        chk("en_next_valid", 32'(mask_valid), 32'd1);
        chk("en_next_mask", 32'(mask), 32'(mmask(adv8(16'hACE1), 8'hFF)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
